fp_divide_iterative: RTL and testbench

- Single-precision IEEE-754 divider, out = in1 / in2. Sibling of the pipelined FP multiplier; shares its flush-to-zero, NaN and rounding conventions and its exception flag set.
- Mantissa divide is an iterative radix-2 restoring loop under an FSM, one quotient bit per cycle.
- Uses a valid/ready input handshake, so one operation is in flight at a time.

---
 rtl/fp_divide_iterative.sv | 273 +++++++++++++++++++++++++++
 tb/tb_fp_divide_iterative.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divide_iterative.sv
// fp_divide_iterative
//   Single-precision IEEE-754 divider, out = in1 / in2.
//   The mantissa quotient comes from a radix-2 restoring loop that produces
//   one quotient bit per cycle. An FSM with states IDLE, DIV, ROUND and
//   SPECIAL sequences each operation. Only one operation is in flight at a time.
//   Denormal inputs are flushed to a zero of the same sign.
//
// Handshake: an operand set is accepted on a rising edge where in_ready=1
//   (the FSM is in IDLE) and valid_data_in=1. valid_data_in is ignored while
//   busy and is not queued. The result is presented with a one-cycle
//   valid_data_out pulse. out and the flags hold until the next result.
//
// Parameters:
//   EARLY_SPECIAL  1: special operands finish in 1 cycle through SPECIAL.
//                  0: special operands run the full DIV/ROUND sequence and
//                     override the result in ROUND (27 cycles for every op).
//
// Optional feature macro: FP_DIV_FLUSH_EN
//   When defined, a flush input exists. flush=1 outside IDLE aborts the
//   operation at the next edge without a result. flush=1 in IDLE blocks
//   an accept.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   valid_data_in      operand strobe
//   in_ready           high while IDLE (combinational from state)
//   in1, in2           dividend, divisor
//   rounding_mode      0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; others act as RTZ
//   flush              abort (FP_DIV_FLUSH_EN only)
//   out                result
//   overflow, underflow, inexact, invalid_operation, divide_by_zero  flags
//   valid_data_out     one-cycle result pulse
module fp_divide_iterative #(
  parameter int unsigned EARLY_SPECIAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_data_in,
  output logic        in_ready,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  rounding_mode,
`ifdef FP_DIV_FLUSH_EN
  input  logic        flush,
`endif
  output logic [31:0] out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        invalid_operation,
  output logic        divide_by_zero,
  output logic        valid_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_SPECIAL} state_t;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  state_t             state_q;
  logic [4:0]         cnt_q;
  logic [25:0]        r_q;
  logic [23:0]        b_q;
  logic [25:0]        q_q;
  logic signed [9:0]  e_q;
  logic               sign_q;
  logic [2:0]         rm_q;
  logic               spec_q;
  logic [31:0]        spec_res_q;
  logic               spec_uf_q;
  logic               spec_inv_q;
  logic               spec_dbz_q;

  logic flush_act;
`ifdef FP_DIV_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  assign in_ready = (state_q == S_IDLE);

  // Operand classification (combinational on in1/in2)
  logic [7:0]  ea, eb;
  logic [22:0] ma, mb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_d;
  assign ea     = in1[30:23];
  assign eb     = in2[30:23];
  assign ma     = in1[22:0];
  assign mb     = in2[22:0];
  assign a_zero = (ea == 8'd0);          // includes flushed denormals
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
  assign sign_d = in1[31] ^ in2[31];

  logic        sp_hit, sp_inv, sp_dbz, sp_uf;
  logic [31:0] sp_res;
  always_comb begin
    sp_hit = 1'b1;
    sp_inv = 1'b0;
    sp_dbz = 1'b0;
    sp_res = 32'd0;
    sp_uf  = (a_zero && ma != 23'd0) || (b_zero && mb != 23'd0);
    if (a_nan && ma[22])                        sp_res = in1;
    else if (b_nan && mb[22])                   sp_res = in2;
    else if (a_nan) begin sp_res = in1 | 32'h0040_0000; sp_inv = 1'b1; end
    else if (b_nan) begin sp_res = in2 | 32'h0040_0000; sp_inv = 1'b1; end
    else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res = {sign_d, 31'h7FC0_0000};
      sp_inv = 1'b1;
    end
    else if (a_inf)                             sp_res = {sign_d, 8'hFF, 23'd0};
    else if (b_inf || a_zero)                   sp_res = {sign_d, 31'd0};
    else if (b_zero) begin
      sp_res = {sign_d, 8'hFF, 23'd0};
      sp_dbz = 1'b1;
    end
    else                                        sp_hit = 1'b0;
  end

  // Pre-normalise so the quotient always lies in [1,2): the first quotient
  // bit is then the hidden 1.
  logic [23:0]       a_man, b_man;
  logic              a_lt;
  logic [25:0]       r_init;
  logic signed [9:0] e_init;
  assign a_man  = {1'b1, ma};
  assign b_man  = {1'b1, mb};
  assign a_lt   = (a_man < b_man);
  assign r_init = a_lt ? {1'b0, a_man, 1'b0} : {2'b00, a_man};
  assign e_init = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                  - (a_lt ? 10'sd1 : 10'sd0);

  // One restoring-division step
  logic [25:0] b_ext, r_sel, r_step;
  logic        qbit;
  assign b_ext  = {2'b00, b_q};
  assign qbit   = (r_q >= b_ext);
  assign r_sel  = qbit ? (r_q - b_ext) : r_q;
  assign r_step = {r_sel[24:0], 1'b0};

  // Rounding of the finished quotient
  logic              g_bit, r_bit, s_bit, lsb, up, inx;
  logic [24:0]       m_sum;
  logic [22:0]       frac_r;
  logic signed [9:0] e_r;
  logic [31:0]       rnd_out;
  logic              rnd_ov, rnd_uf;
  assign g_bit = q_q[1];
  assign r_bit = q_q[0];
  assign s_bit = (r_q != 26'd0);
  assign lsb   = q_q[2];
  assign inx   = g_bit | r_bit | s_bit;

  always_comb begin
    case (rm_q)
      RM_RNE:  up = g_bit & (r_bit | s_bit | lsb);
      RM_RDN:  up = sign_q & inx;
      RM_RUP:  up = ~sign_q & inx;
      RM_RMM:  up = g_bit;
      default: up = 1'b0;
    endcase
    m_sum = {1'b0, q_q[25:2]} + {24'd0, up};
    if (m_sum[24]) begin
      frac_r = 23'd0;
      e_r    = e_q + 10'sd1;
    end else begin
      frac_r = m_sum[22:0];
      e_r    = e_q;
    end
    rnd_ov  = 1'b0;
    rnd_uf  = 1'b0;
    rnd_out = {sign_q, e_r[7:0], frac_r};
    if (e_r > 10'sd254) begin
      rnd_ov = 1'b1;
      case (rm_q)
        RM_RTZ:  rnd_out = {sign_q, 8'hFE, 23'h7F_FFFF};
        RM_RDN:  rnd_out = sign_q ? 32'hFF80_0000 : 32'h7F7F_FFFF;
        RM_RUP:  rnd_out = sign_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
        default: rnd_out = {sign_q, 8'hFF, 23'd0};
      endcase
    end else if (e_r <= 10'sd0) begin
      rnd_uf  = 1'b1;
      rnd_out = {sign_q, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      cnt_q             <= 5'd0;
      r_q               <= 26'd0;
      b_q               <= 24'd0;
      q_q               <= 26'd0;
      e_q               <= 10'sd0;
      sign_q            <= 1'b0;
      rm_q              <= 3'd0;
      spec_q            <= 1'b0;
      spec_res_q        <= 32'd0;
      spec_uf_q         <= 1'b0;
      spec_inv_q        <= 1'b0;
      spec_dbz_q        <= 1'b0;
      out               <= 32'd0;
      overflow          <= 1'b0;
      underflow         <= 1'b0;
      inexact           <= 1'b0;
      invalid_operation <= 1'b0;
      divide_by_zero    <= 1'b0;
      valid_data_out    <= 1'b0;
    end else begin
      valid_data_out <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_data_in && !flush_act) begin
            sign_q     <= sign_d;
            rm_q       <= (rounding_mode > RM_RMM) ? RM_RTZ : rounding_mode;
            spec_q     <= sp_hit;
            spec_res_q <= sp_res;
            spec_uf_q  <= sp_uf;
            spec_inv_q <= sp_inv;
            spec_dbz_q <= sp_dbz;
            r_q        <= r_init;
            b_q        <= b_man;
            q_q        <= 26'd0;
            e_q        <= e_init;
            cnt_q      <= 5'd25;
            state_q    <= (sp_hit && EARLY_SPECIAL != 0) ? S_SPECIAL : S_DIV;
          end
        end
        S_DIV: begin
          if (flush_act) state_q <= S_IDLE;
          else begin
            r_q   <= r_step;
            q_q   <= {q_q[24:0], qbit};
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_q <= S_ROUND;
          end
        end
        S_ROUND, S_SPECIAL: begin
          if (flush_act) state_q <= S_IDLE;
          else begin
            // spec_q is only ever set here in ROUND when EARLY_SPECIAL=0
            if (spec_q) begin
              out               <= spec_res_q;
              overflow          <= 1'b0;
              underflow         <= spec_uf_q;
              inexact           <= 1'b0;
              invalid_operation <= spec_inv_q;
              divide_by_zero    <= spec_dbz_q;
            end else begin
              out               <= rnd_out;
              overflow          <= rnd_ov;
              underflow         <= rnd_uf;
              inexact           <= inx | rnd_ov | rnd_uf;
              invalid_operation <= 1'b0;
              divide_by_zero    <= 1'b0;
            end
            valid_data_out <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_divide_iterative.sv
// Directed testbench for fp_divide_iterative (default parameters).
// Flags are compared as {overflow, underflow, inexact, invalid, divide_by_zero}.
module tb_fp_divide_iterative;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_data_in = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic [2:0]  rounding_mode = 3'd0;
  logic [31:0] out;
  logic        overflow, underflow, inexact, invalid_operation, divide_by_zero;
  logic        valid_data_out;
`ifdef FP_DIV_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  fp_divide_iterative dut (
    .clk               (clk),
    .rst               (rst),
    .valid_data_in     (valid_data_in),
    .in_ready          (in_ready),
    .in1               (in1),
    .in2               (in2),
    .rounding_mode     (rounding_mode),
`ifdef FP_DIV_FLUSH_EN
    .flush             (flush),
`endif
    .out               (out),
    .overflow          (overflow),
    .underflow         (underflow),
    .inexact           (inexact),
    .invalid_operation (invalid_operation),
    .divide_by_zero    (divide_by_zero),
    .valid_data_out    (valid_data_out)
  );

  always #5 clk = ~clk;

  // Normal-path vectors: a, b, mode, expected out, expected flags
  localparam int NN = 16;
  localparam logic [31:0] N_A [NN] = '{
    32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h3F800000,
    32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000,
    32'h3F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h7F7FFFFF,
    32'h7F7FFFFF, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h00800000};
  localparam logic [31:0] N_B [NN] = '{
    32'h40000000, 32'h40000000, 32'h3F800000, 32'h40400000,
    32'h40400000, 32'h40400000, 32'h40400000, 32'h40400000,
    32'h40400000, 32'h40400000, 32'h3F000000, 32'h3F000000,
    32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h4B000000};
  localparam logic [2:0] N_RM [NN] = '{
    3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd4, 3'd2, 3'd3,
    3'd7, 3'd2, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd3, 3'd0};
  localparam logic [31:0] N_EXP [NN] = '{
    32'h40400000, 32'hC0400000, 32'h3F800000, 32'h3EAAAAAB,
    32'h3EAAAAAA, 32'h3EAAAAAB, 32'hBEAAAAAB, 32'hBEAAAAAA,
    32'h3EAAAAAA, 32'h3EAAAAAA, 32'h7F800000, 32'h7F7FFFFF,
    32'h7F7FFFFF, 32'h7F800000, 32'hFF7FFFFF, 32'h00000000};
  localparam logic [4:0] N_FL [NN] = '{
    5'b00000, 5'b00000, 5'b00000, 5'b00100,
    5'b00100, 5'b00100, 5'b00100, 5'b00100,
    5'b00100, 5'b00100, 5'b10100, 5'b10100,
    5'b10100, 5'b10100, 5'b10100, 5'b01100};

  // Special-path vectors
  localparam int NS = 9;
  localparam logic [31:0] S_A [NS] = '{
    32'h3F800000, 32'h00000000, 32'h00000001, 32'h7FC00001, 32'h7F800001,
    32'h3F800000, 32'h7F800000, 32'hBF800000, 32'h7F800000};
  localparam logic [31:0] S_B [NS] = '{
    32'h00000000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
    32'h7F800000, 32'h40000000, 32'h00000000, 32'hFF800000};
  localparam logic [31:0] S_EXP [NS] = '{
    32'h7F800000, 32'h7FC00000, 32'h00000000, 32'h7FC00001, 32'h7FC00001,
    32'h00000000, 32'h7F800000, 32'hFF800000, 32'hFFC00000};
  localparam logic [4:0] S_FL [NS] = '{
    5'b00001, 5'b00010, 5'b01000, 5'b00000, 5'b00010,
    5'b00000, 5'b00000, 5'b00001, 5'b00010};

  // Driver: issue one operation, wait (bounded) for the result pulse.
  // lat counts rising edges from the accept edge to the pulse; busy_ok
  // goes low if in_ready was seen high before the pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, output logic [31:0] res,
                        output logic [4:0] fl, output int lat,
                        output logic busy_ok);
    @(negedge clk);
    in1 = a; in2 = b; rounding_mode = rm; valid_data_in = 1'b1;
    @(posedge clk);
    #1 valid_data_in = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!valid_data_out && in_ready) busy_ok = 1'b0;
    end while (!valid_data_out && lat < 200);
    res = out;
    fl  = {overflow, underflow, inexact, invalid_operation, divide_by_zero};
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (out !== 32'd0) $display("FAIL reset_out: got %h exp 00000000", out); else passed++;
    checks++; if ({overflow, underflow, inexact, invalid_operation, divide_by_zero} !== 5'b0)
      $display("FAIL reset_flags: got %b exp 00000",
               {overflow, underflow, inexact, invalid_operation, divide_by_zero});
    else passed++;
    checks++; if (valid_data_out !== 1'b0) $display("FAIL reset_valid: got %b exp 0", valid_data_out); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", in_ready); else passed++;
    rst = 1'b0;
  endtask

  task automatic run_normal_range(input int lo, input int hi, input string name);
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    logic        busy_ok;
    for (int i = lo; i <= hi; i++) begin
      run_op(N_A[i], N_B[i], N_RM[i], res, fl, lat, busy_ok);
      checks++; if (res !== N_EXP[i]) $display("FAIL %s_out[%0d]: got %h exp %h", name, i, res, N_EXP[i]); else passed++;
      checks++; if (fl !== N_FL[i]) $display("FAIL %s_flags[%0d]: got %b exp %b", name, i, fl, N_FL[i]); else passed++;
      checks++; if (lat !== 27) $display("FAIL %s_latency[%0d]: got %0d exp 27", name, i, lat); else passed++;
      checks++; if (busy_ok !== 1'b1) $display("FAIL %s_ready_busy[%0d]: got ready high while busy exp low", name, i); else passed++;
    end
  endtask

  task automatic test_basic();
    run_normal_range(0, 2, "basic");
  endtask

  task automatic test_rounding();
    run_normal_range(3, 9, "round");
  endtask

  task automatic test_overflow_underflow();
    run_normal_range(10, 15, "ovuf");
  endtask

  task automatic test_special();
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    logic        busy_ok;
    for (int i = 0; i < NS; i++) begin
      run_op(S_A[i], S_B[i], 3'd0, res, fl, lat, busy_ok);
      checks++; if (res !== S_EXP[i]) $display("FAIL special_out[%0d]: got %h exp %h", i, res, S_EXP[i]); else passed++;
      checks++; if (fl !== S_FL[i]) $display("FAIL special_flags[%0d]: got %b exp %b", i, fl, S_FL[i]); else passed++;
      checks++; if (lat !== 1) $display("FAIL special_latency[%0d]: got %0d exp 1", i, lat); else passed++;
    end
  endtask

  // Hold valid_data_in high throughout: the operands change after the first
  // accept and must be ignored until the result cycle, where they are taken.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    in1 = 32'h40C00000; in2 = 32'h40000000; rounding_mode = 3'd0; valid_data_in = 1'b1;
    @(posedge clk);
    #1 in1 = 32'h3F800000; in2 = 32'h40400000;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!valid_data_out && lat < 200);
    checks++; if (lat !== 27) $display("FAIL b2b_first_latency: got %0d exp 27", lat); else passed++;
    checks++; if (out !== 32'h40400000) $display("FAIL b2b_first_out: got %h exp 40400000", out); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_at_valid: got %b exp 1", in_ready); else passed++;
    @(posedge clk);
    #1 valid_data_in = 1'b0;
    checks++; if (in_ready !== 1'b0) $display("FAIL b2b_second_accept: got ready %b exp 0", in_ready); else passed++;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!valid_data_out && lat < 200);
    checks++; if (lat !== 27) $display("FAIL b2b_second_latency: got %0d exp 27", lat); else passed++;
    checks++; if (out !== 32'h3EAAAAAB) $display("FAIL b2b_second_out: got %h exp 3EAAAAAB", out); else passed++;
    checks++; if (inexact !== 1'b1) $display("FAIL b2b_second_inexact: got %b exp 1", inexact); else passed++;
  endtask

`ifdef FP_DIV_FLUSH_EN
  task automatic test_flush();
    int pulses;
    @(negedge clk);
    in1 = 32'h40C00000; in2 = 32'h40000000; rounding_mode = 3'd0; valid_data_in = 1'b1;
    @(posedge clk);
    #1 valid_data_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_idle: got ready %b exp 1", in_ready); else passed++;
    checks++; if (out !== 32'h3EAAAAAB) $display("FAIL flush_out_kept: got %h exp 3EAAAAAB", out); else passed++;
    pulses = 0;
    repeat (30) begin @(posedge clk); #1; if (valid_data_out) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL flush_no_valid: got %0d pulses exp 0", pulses); else passed++;
    // flush in IDLE must block a same-cycle accept
    @(negedge clk);
    flush = 1'b1; valid_data_in = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; valid_data_in = 1'b0;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_blocks_accept: got ready %b exp 1", in_ready); else passed++;
  endtask
`endif

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    in1 = 32'h40C00000; in2 = 32'h40000000; rounding_mode = 3'd0; valid_data_in = 1'b1;
    @(posedge clk);
    #1 valid_data_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (out !== 32'd0) $display("FAIL rstmid_out: got %h exp 00000000", out); else passed++;
    checks++; if ({overflow, underflow, inexact, invalid_operation, divide_by_zero} !== 5'b0)
      $display("FAIL rstmid_flags: got %b exp 00000",
               {overflow, underflow, inexact, invalid_operation, divide_by_zero});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b exp 1", in_ready); else passed++;
    pulses = 0;
    repeat (30) begin @(posedge clk); #1; if (valid_data_out) pulses++; end
    checks++; if (pulses !== 0) $display("FAIL rstmid_no_valid: got %0d pulses exp 0", pulses); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_overflow_underflow();
    test_back_to_back();
`ifdef FP_DIV_FLUSH_EN
    test_flush();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
